// File: rtl/ins_fetcher.sv
// Instruction fetch sequencer: one outstanding 32-bit read, static next-PC
// prediction, and a one-cycle push of {ins, pc, pred_pc} into the queue.
module ins_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ready,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        full,
  output logic        push,
  output logic [31:0] push_ins,
  output logic [31:0] push_pc,
  output logic [31:0] push_pred_pc,
  output logic [1:0]  dbg_state
);

  // Memory handshake: mem_req rises with mem_addr and both hold until the
  // cycle mem_done is sampled high; a request is never withdrawn early.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        push_q, push_d;
  logic [31:0] push_ins_q, push_ins_d;
  logic [31:0] push_pc_q, push_pc_d;
  logic [31:0] push_pred_q, push_pred_d;
  logic [31:0] pred;
  logic [31:0] j_imm;
  logic [31:0] b_imm;

  assign j_imm = {{11{mem_data[31]}}, mem_data[31], mem_data[19:12], mem_data[20],
                  mem_data[30:21], 1'b0};
  assign b_imm = {{19{mem_data[31]}}, mem_data[31], mem_data[7], mem_data[30:25],
                  mem_data[11:8], 1'b0};

  // Only JAL and backward branches are predicted taken; JALR falls through.
  always_comb begin
    pred = pc_q + 32'd4;
    if (mem_data[6:0] == 7'b1101111) begin
      pred = pc_q + j_imm;
    end else if (mem_data[6:0] == 7'b1100011 && mem_data[31]) begin
      pred = pc_q + b_imm;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    push_d      = push_q;
    push_ins_d  = push_ins_q;
    push_pc_d   = push_pc_q;
    push_pred_d = push_pred_q;
    if (clear) begin
      pc_d   = clear_pc;
      push_d = 1'b0;
      if (state_q != IDLE) begin
        if (mem_done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
    end else if (ready) begin
      push_d = 1'b0;
      case (state_q)
        IDLE: begin
          // push_q high means the queue's full flag does not yet see that entry.
          if (!full && !push_q) begin
            state_d    = WAIT;
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state_d     = IDLE;
            mem_req_d   = 1'b0;
            push_d      = 1'b1;
            push_ins_d  = mem_data;
            push_pc_d   = pc_q;
            push_pred_d = pred;
            pc_d        = pred;
          end
        end
        DRAIN: begin
          if (mem_done) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      push_q      <= 1'b0;
      push_ins_q  <= 32'h0;
      push_pc_q   <= 32'h0;
      push_pred_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      push_q      <= push_d;
      push_ins_q  <= push_ins_d;
      push_pc_q   <= push_pc_d;
      push_pred_q <= push_pred_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_addr     = mem_addr_q;
  assign push         = push_q;
  assign push_ins     = push_ins_q;
  assign push_pc      = push_pc_q;
  assign push_pred_pc = push_pred_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed bench for ins_fetcher: a scripted memory responder drives mem_done,
// and each scenario task checks the fetcher's outputs against hand-derived values.
module tb_ins_fetcher;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic        clk;
  logic        reset;
  logic        ready;
  logic        clear;
  logic [31:0] clear_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
  logic        full;
  logic        push;
  logic [31:0] push_ins;
  logic [31:0] push_pc;
  logic [31:0] push_pred_pc;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  ins_fetcher #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .clear        (clear),
    .clear_pc     (clear_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_done     (mem_done),
    .mem_data     (mem_data),
    .full         (full),
    .push         (push),
    .push_ins     (push_ins),
    .push_pc      (push_pc),
    .push_pred_pc (push_pred_pc),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data, input int lat,
                       output logic [31:0] addr, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    while (!mem_req && n < 20) begin
      step();
      n++;
    end
    ok   = mem_req;
    addr = mem_addr;
    if (ok) begin
      repeat (lat - 1) step();
      mem_data = data;
      mem_done = 1'b1;
      step();
      mem_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ready = 1'b1; clear = 1'b0; clear_pc = 32'h0;
    mem_done = 1'b0; mem_data = 32'h0; full = 1'b0;
    repeat (2) step();
    checks++;
    if ({mem_req, push, dbg_state} !== {1'b0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL reset_ctrl: req/push/state=%b%b%0d expected 000", mem_req, push, dbg_state);
    end
    checks++;
    if ({mem_addr, push_ins, push_pc, push_pred_pc} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h ins=%h pc=%h pred=%h expected all 0",
               mem_addr, push_ins, push_pc, push_pred_pc);
    end
    reset = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || dbg_state !== S_WAIT) begin
      errors++;
      $display("FAIL first_issue: req=%b addr=%h state=%0d expected 1 00000000 1",
               mem_req, mem_addr, dbg_state);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    logic ok;
    fetch(32'h00000013, 3, a, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL seq_timeout: no mem_req");
    end
    checks++;
    if ({push, push_ins, push_pc, push_pred_pc} !== {1'b1, 32'h13, 32'h0, 32'h4}) begin
      errors++;
      $display("FAIL seq_push: push=%b ins=%h pc=%h pred=%h expected 1 00000013 0 4",
               push, push_ins, push_pc, push_pred_pc);
    end
    step();
    checks++;
    if (push !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL seq_bubble: push=%b req=%b expected 0 0", push, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL seq_next: req=%b addr=%h expected 1 00000004", mem_req, mem_addr);
    end
  endtask

  task automatic test_clear_wait();
    int held;
    step();
    clear = 1'b1; clear_pc = 32'h80;
    step();
    clear = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || push !== 1'b0 || dbg_state !== S_DRAIN) begin
      errors++;
      $display("FAIL clear_drain: req=%b push=%b state=%0d expected 1 0 2",
               mem_req, push, dbg_state);
    end
    held = 0;
    repeat (2) begin
      step();
      if (mem_req === 1'b1 && mem_addr === 32'h4) held++;
    end
    checks++;
    if (held != 2) begin
      errors++;
      $display("FAIL clear_hold: cycles held=%0d expected 2", held);
    end
    mem_data = 32'h0100006F; mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    checks++;
    if (push !== 1'b0 || mem_req !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL drain_done: push=%b req=%b state=%0d expected 0 0 0",
               push, mem_req, dbg_state);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL clear_redirect: req=%b addr=%h expected 1 00000080", mem_req, mem_addr);
    end
  endtask

  task automatic test_clear_done();
    step();
    clear = 1'b1; clear_pc = 32'h100;
    mem_data = 32'h00000013; mem_done = 1'b1;
    step();
    clear = 1'b0; mem_done = 1'b0;
    checks++;
    if (push !== 1'b0 || mem_req !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL clear_with_done: push=%b req=%b state=%0d expected 0 0 0",
               push, mem_req, dbg_state);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL clear_done_next: req=%b addr=%h expected 1 00000100", mem_req, mem_addr);
    end
  endtask

  task automatic test_predict();
    logic [31:0] t_addr [6];
    logic [31:0] t_ins  [6];
    logic [31:0] t_pred [6];
    logic [31:0] a;
    logic ok;
    t_addr = '{32'h100, 32'h110, 32'h200, 32'h1FC, 32'h200, 32'h204};
    t_ins  = '{32'h0100006F, 32'h0F00006F, 32'hFE000EE3, 32'h00000013,
               32'h00000463, 32'h000080E7};
    t_pred = '{32'h110, 32'h200, 32'h1FC, 32'h200, 32'h204, 32'h208};
    for (int i = 0; i < 6; i++) begin
      fetch(t_ins[i], 1 + (i % 3), a, ok);
      checks++;
      if (!ok || a !== t_addr[i]) begin
        errors++;
        $display("FAIL pred_addr[%0d]: ok=%b addr=%h expected %h", i, ok, a, t_addr[i]);
      end
      checks++;
      if ({push, push_ins, push_pc, push_pred_pc} !== {1'b1, t_ins[i], t_addr[i], t_pred[i]}) begin
        errors++;
        $display("FAIL pred_push[%0d]: push=%b ins=%h pc=%h pred=%h expected 1 %h %h %h",
                 i, push, push_ins, push_pc, push_pred_pc, t_ins[i], t_addr[i], t_pred[i]);
      end
    end
  endtask

  task automatic test_full();
    int rose;
    full = 1'b1;
    rose = 0;
    repeat (5) begin
      step();
      if (mem_req !== 1'b0) rose++;
    end
    checks++;
    if (rose != 0) begin
      errors++;
      $display("FAIL full_block: req high cycles=%0d expected 0", rose);
    end
    full = 1'b0;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h208) begin
      errors++;
      $display("FAIL full_release: req=%b addr=%h expected 1 00000208", mem_req, mem_addr);
    end
  endtask

  task automatic test_ready_hold();
    logic [31:0] a;
    logic ok;
    int held;
    int accepted;
    fetch(32'h00000013, 2, a, ok);
    ready = 1'b0;
    held = 0;
    repeat (3) begin
      step();
      if (push === 1'b1 && mem_req === 1'b0 && dbg_state === S_IDLE) held++;
    end
    checks++;
    if (!ok || held != 3) begin
      errors++;
      $display("FAIL ready_freeze: ok=%b held=%0d expected 1 3", ok, held);
    end
    ready = 1'b1;
    accepted = 0;
    repeat (6) begin
      if (push && ready) accepted++;
      step();
    end
    checks++;
    if (accepted != 1) begin
      errors++;
      $display("FAIL ready_single_push: accepted=%0d expected 1", accepted);
    end
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h20C) begin
      errors++;
      $display("FAIL ready_pc_hold: req=%b addr=%h expected 1 0000020c", mem_req, mem_addr);
    end
  endtask

  task automatic test_async_reset();
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || push !== 1'b0 || mem_addr !== 32'h0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL async_reset: req=%b push=%b addr=%h state=%0d expected 0 0 0 0",
               mem_req, push, mem_addr, dbg_state);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc: req=%b addr=%h expected 1 00000000", mem_req, mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_clear_wait();
    test_clear_done();
    test_predict();
    test_full();
    test_ready_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
